// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and constants for the 4-way round-robin packet arbiter.
package mux_rr_arbiter_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Producer-side and consumer-side stream signals of the arbiter.
interface mux_rr_arbiter_if
  import mux_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic [NUM_REQ-1:0]       in_valid;
  logic [NUM_REQ-1:0]       in_last;
  logic [NUM_REQ*WIDTH-1:0] in_data;
  logic [NUM_REQ-1:0]       in_ready;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic                     out_last;
  logic [SEL_W-1:0]         out_src;
  logic                     out_ready;

  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_src
  );

  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_src
  );
endinterface

// File: rtl/mux_rr_arbiter_rr_pick4.sv
// Combinational round-robin pick: first set bit of req starting at ptr, wrapping mod 4.
module rr_pick4
  import mux_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   gnt_idx,
  output logic               any
);
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [SEL_W-1:0]     off;

  // rot[k] = req[(ptr+k) mod 4], so bit 0 is the highest-priority requester
  assign dbl = {req, req};
  assign rot = dbl[{1'b0, ptr} +: NUM_REQ];

  always_comb begin
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (rot[i]) off = SEL_W'(i);
  end

  assign gnt_idx = ptr + off;
  assign any     = |req;
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin 4:1 packet arbiter: grant held until in_last, one registered output stage.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
)(
  input  logic             clk,
  input  logic             rst_n,
  mux_rr_arbiter_if.slave  bus
);
  state_t                          state, state_n;
  logic [SEL_W-1:0]                rr_ptr, rr_ptr_n, grant, grant_n;
  logic [SEL_W-1:0]                winner, sel;
  logic                            any, load, xfer, sel_last;
  logic [NUM_REQ-1:0]              ready;
  logic [NUM_REQ-1:0][WIDTH-1:0]   lane_data;

  logic                            out_valid_q, out_last_q;
  logic [WIDTH-1:0]                out_data_q;
  logic [SEL_W-1:0]                out_src_q;

  assign lane_data = bus.in_data;

  rr_pick4 u_pick (
    .req     (bus.in_valid),
    .ptr     (rr_ptr),
    .gnt_idx (winner),
    .any     (any)
  );

  // Output slot is free when empty or draining this cycle
  assign load = ~out_valid_q | bus.out_ready;

  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    grant_n  = grant;
    ready    = '0;
    sel      = (state == LOCKED) ? grant : winner;
    case (state)
      IDLE:    if (any && load) ready = onehot(winner);
      LOCKED:  if (bus.in_valid[grant] && load) ready = onehot(grant);
      default: ready = '0;
    endcase
    if (!rst_n) ready = '0;
    xfer     = |ready;
    sel_last = bus.in_last[sel];
    if (xfer) begin
      if (state == IDLE) begin
        if (sel_last) begin
          rr_ptr_n = sel + SEL_W'(1);
        end else begin
          state_n = LOCKED;
          grant_n = sel;
        end
      end else if (sel_last) begin
        state_n  = IDLE;
        rr_ptr_n = sel + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      grant  <= '0;
    end else begin
      state  <= state_n;
      rr_ptr <= rr_ptr_n;
      grant  <= grant_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= lane_data[sel];
      out_last_q  <= sel_last;
      out_src_q   <= sel;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with hand-computed expectations.
module tb_mux_rr_arbiter;
  import mux_rr_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter_if #(.WIDTH(8)) bus ();
  mux_rr_arbiter #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic l, input logic [1:0] s);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, ".data"},  32'(bus.out_data),  32'(d));
    chk({tag, ".last"},  32'(bus.out_last),  32'(l));
    chk({tag, ".src"},   32'(bus.out_src),   32'(s));
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l);
    bus.in_valid = v;
    bus.in_last  = l;
    #1;
  endtask

  task automatic put(input int i, input logic [7:0] d);
    bus.in_data[i*8 +: 8] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    drive(4'b1111, 4'b1111);
    tick();
    tick();
    chk_out("reset", 1'b0, 8'h00, 1'b0, 2'd0);
    chk("reset.ready", 32'(bus.in_ready), 32'h0);

    // 1: all valid single-beat packets rotate 0,1,2,3,0,1
    for (int i = 0; i < 4; i++) put(i, 8'(8'h10 + i));
    rst_n = 1'b1;
    #1;
    chk("t1.ready0", 32'(bus.in_ready), 32'b0001);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_out($sformatf("t1.beat%0d", k), 1'b1, 8'(8'h10 + k % 4), 1'b1, 2'(k % 4));
      chk($sformatf("t1.ready%0d", k + 1), 32'(bus.in_ready), 32'(4'b0001 << ((k + 1) % 4)));
    end

    // 2: requester 2 locks for 3 beats while requester 1 waits (ptr now 2)
    put(2, 8'hA1);
    put(1, 8'hB1);
    drive(4'b0110, 4'b0000);
    chk("t2.ready_a1", 32'(bus.in_ready), 32'b0100);
    tick();
    chk_out("t2.a1", 1'b1, 8'hA1, 1'b0, 2'd2);
    put(2, 8'hA2);
    #1;
    chk("t2.ready_a2", 32'(bus.in_ready), 32'b0100);
    tick();
    chk_out("t2.a2", 1'b1, 8'hA2, 1'b0, 2'd2);
    put(2, 8'hA3);
    drive(4'b0110, 4'b0100);
    chk("t2.ready_a3", 32'(bus.in_ready), 32'b0100);
    tick();
    chk_out("t2.a3", 1'b1, 8'hA3, 1'b1, 2'd2);
    drive(4'b0010, 4'b0010);
    chk("t2.ready_b1", 32'(bus.in_ready), 32'b0010);
    tick();
    chk_out("t2.b1", 1'b1, 8'hB1, 1'b1, 2'd1);

    // 3: backpressure holds 0x55, next beat loads on release
    put(0, 8'h55);
    drive(4'b0001, 4'b0001);
    tick();
    chk_out("t3.load55", 1'b1, 8'h55, 1'b1, 2'd0);
    bus.out_ready = 1'b0;
    put(0, 8'h66);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t3.ready_stall%0d", k), 32'(bus.in_ready), 32'h0);
      tick();
      chk_out($sformatf("t3.hold%0d", k), 1'b1, 8'h55, 1'b1, 2'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("t3.ready_release", 32'(bus.in_ready), 32'b0001);
    tick();
    chk_out("t3.load66", 1'b1, 8'h66, 1'b1, 2'd0);

    // 4: locked requester 3 gaps for 2 cycles while requester 0 is valid
    put(3, 8'hC1);
    put(0, 8'hD1);
    drive(4'b1001, 4'b0001);
    chk("t4.ready_c1", 32'(bus.in_ready), 32'b1000);
    tick();
    chk_out("t4.c1", 1'b1, 8'hC1, 1'b0, 2'd3);
    drive(4'b0001, 4'b0001);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("t4.ready_gap%0d", k), 32'(bus.in_ready), 32'h0);
      tick();
      chk_out($sformatf("t4.gap%0d", k), 1'b0, 8'hC1, 1'b0, 2'd3);
    end
    put(3, 8'hC2);
    drive(4'b1001, 4'b1001);
    chk("t4.ready_c2", 32'(bus.in_ready), 32'b1000);
    tick();
    chk_out("t4.c2", 1'b1, 8'hC2, 1'b1, 2'd3);
    drive(4'b0001, 4'b0001);
    chk("t4.ready_d1", 32'(bus.in_ready), 32'b0001);
    tick();
    chk_out("t4.d1", 1'b1, 8'hD1, 1'b1, 2'd0);

    // 5: reset during a packet locked to requester 1
    put(1, 8'hE1);
    drive(4'b0010, 4'b0000);
    chk("t5.ready_e1", 32'(bus.in_ready), 32'b0010);
    tick();
    chk_out("t5.e1", 1'b1, 8'hE1, 1'b0, 2'd1);
    rst_n = 1'b0;
    drive(4'b1111, 4'b1111);
    chk("t5.ready_in_rst", 32'(bus.in_ready), 32'h0);
    tick();
    chk_out("t5.after_rst", 1'b0, 8'h00, 1'b0, 2'd0);
    chk("t5.ready_after_rst", 32'(bus.in_ready), 32'h0);
    rst_n = 1'b1;
    put(0, 8'h50);
    #1;
    chk("t5.ready_release", 32'(bus.in_ready), 32'b0001);
    tick();
    chk_out("t5.first", 1'b1, 8'h50, 1'b1, 2'd0);

    // 6: lone requester 3 gets 4 back-to-back packets
    drive(4'b1000, 4'b1000);
    for (int k = 0; k < 4; k++) begin
      put(3, 8'(8'hF0 + k));
      #1;
      chk($sformatf("t6.ready%0d", k), 32'(bus.in_ready), 32'b1000);
      tick();
      chk_out($sformatf("t6.beat%0d", k), 1'b1, 8'(8'hF0 + k), 1'b1, 2'd3);
    end
    drive(4'b0000, 4'b0000);
    tick();
    chk("t6.drain", 32'(bus.out_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
